// File: rtl/keypad_emulator.sv
// keypad_emulator: queues key positions and plays each one into a 4x4 matrix
// keypad interface for a row scanner. Define KEYPAD_EMU_BOUNCE_EN for contact bounce.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 200,
  parameter int GAP_CYCLES    = 200,
  parameter int BOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  input  logic [3:0] key_pos,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       key_down,
  output logic       key_done,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 8 || GAP_CYCLES < 8 ||
      BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= GAP_CYCLES) begin : g_bad_params
    $error("keypad_emulator: illegal timing parameters");
  end

  state_t      state_r;
  state_t      state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic [3:0]  fifo_mem_r [4];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  count_r;
  logic [3:0]  active_r;
  logic        key_down_r;
  logic        key_done_r;
  logic        push_s;
  logic        pop_s;
  logic        contact_s;

  assign key_ready = ~reset & (count_r != 3'd4);
  assign push_s    = key_valid & key_ready;
  assign key_down  = key_down_r;
  assign key_done  = key_done_r;
  assign pending   = count_r;

  // Next-state and down-counter logic for the IDLE/PRESS/GAP sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pop_s   = 1'b0;
    if (reset) begin
      state_s = IDLE;
      cnt_s   = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != 3'd0) begin
            pop_s   = 1'b1;
            cnt_s   = HOLD_LOAD;
            state_s = PRESS;
          end else begin
            state_s = IDLE;
          end
        end
        PRESS: begin
          if (cnt_r == 16'd0) begin
            cnt_s   = GAP_LOAD;
            state_s = GAP;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        GAP: begin
          if (cnt_r == 16'd0) begin
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end
      endcase
    end
  end

  // State, counter, queue pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      active_r   <= 4'd0;
      key_down_r <= 1'b0;
      key_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      // key_done is registered one cycle early so it lands on the last PRESS cycle.
      key_down_r <= (state_s == PRESS);
      key_done_r <= (state_s == PRESS) && (cnt_s == 16'd0);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        active_r <= fifo_mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; needs no reset since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= key_pos;
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LIM = 16'(BOUNCE_CYCLES);
  logic [15:0] elapsed_s;

  // Contact chatters in 4-cycle slices at the start of both PRESS and GAP.
  always_comb begin
    elapsed_s = 16'd0;
    contact_s = 1'b0;
    case (state_r)
      PRESS: begin
        elapsed_s = HOLD_LOAD - cnt_r;
        contact_s = (elapsed_s >= BOUNCE_LIM) | ~elapsed_s[2];
      end
      GAP: begin
        elapsed_s = GAP_LOAD - cnt_r;
        contact_s = (elapsed_s < BOUNCE_LIM) & elapsed_s[2];
      end
      default: begin
        elapsed_s = 16'd0;
        contact_s = 1'b0;
      end
    endcase
  end
`else
  assign contact_s = (state_r == PRESS);
`endif

  // Column sense follows the scanned rows with no clock delay.
  always_comb begin
    columns = 4'b1111;
    if (contact_s && (rows[active_r[3:2]] == 1'b0)) begin
      columns[active_r[1:0]] = 1'b0;
    end else begin
      columns = 4'b1111;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: a schedule-level model predicts every
// press window; a monitor compares DUT outputs each cycle and at press events.
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int G = 18;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows = 4'hF;
  logic [3:0] key_pos = 4'h0;
  logic       key_valid = 1'b0;
  logic [3:0] columns;
  logic       key_ready;
  logic       key_down;
  logic       key_done;
  logic [2:0] pending;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] key;
    int         k;
    int         s;
  } ent_t;

  ent_t       sched[$];
  ent_t       exp_q[$];
  int         last_s = -100000;
  int         rows_mode = 1;
  logic [3:0] rows_fixed = 4'hF;

  keypad_emulator #(
    .HOLD_CYCLES  (H),
    .GAP_CYCLES   (G),
    .BOUNCE_CYCLES(B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .columns  (columns),
    .key_pos  (key_pos),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_down (key_down),
    .key_done (key_done),
    .pending  (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  // Keys accepted but not yet popped by cycle m.
  function automatic int pend_at(int m);
    int c = 0;
    foreach (sched[i]) if (sched[i].k <= m && sched[i].s > m) c++;
    return c;
  endfunction

  function automatic logic down_at(int m);
    foreach (sched[i]) if (m >= sched[i].s && m < sched[i].s + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic done_at(int m);
    foreach (sched[i]) if (m == sched[i].s + H - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic closed_at(int m, int s);
    int ep = m - s;
`ifdef KEYPAD_EMU_BOUNCE_EN
    int eg = m - s - H;
`endif
    if (ep >= 0 && ep < H) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
      return (ep >= B) || ((ep / 4) % 2 == 0);
`else
      return 1'b1;
`endif
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (eg >= 0 && eg < G) return (eg < B) && ((eg / 4) % 2 == 1);
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] cols_at(int m, logic [3:0] r);
    logic [3:0] c = 4'hF;
    foreach (sched[i]) begin
      if (closed_at(m, sched[i].s) && r[sched[i].key[3:2]] == 1'b0) c[sched[i].key[1:0]] = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [3:0] pick_rows(int n);
    logic [3:0] one;
    case (rows_mode)
      0: begin
        case (n % 4)
          0:       return 4'b1110;
          1:       return 4'b1101;
          2:       return 4'b1011;
          default: return 4'b0111;
        endcase
      end
      1: return rows_fixed;
      default: begin
        case ($urandom_range(0, 2))
          0: begin
            one = 4'b0001 << $urandom_range(0, 3);
            return ~one;
          end
          1:       return 4'b1111;
          default: return 4'($urandom);
        endcase
      end
    endcase
  endfunction

  initial begin : monitor
    logic prev_down = 1'b0;
    logic cur_valid = 1'b0;
    ent_t cur;
    int   m;
    forever begin
      @(posedge clk);
      #1;
      m = cyc;
      chk("pending", m, 32'(pending), 32'(pend_at(m)));
      chk("key_ready", m, 32'(key_ready), 32'(!reset && (pend_at(m) < 4)));
      chk("key_down", m, 32'(key_down), 32'(down_at(m)));
      chk("key_done", m, 32'(key_done), 32'(done_at(m)));
      chk("columns", m, 32'(columns), 32'(cols_at(m, rows)));
      if (key_down === 1'b1 && !prev_down) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL press_unexpected at cycle %0d: got a press expected none queued", m);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          chk("press_start", m, m, cur.s);
        end
      end
      if (key_done === 1'b1) begin
        if (!cur_valid) begin
          checks++;
          errors++;
          $display("FAIL done_orphan at cycle %0d: got key_done expected no pulse", m);
        end else begin
          chk("done_cycle", m, m, cur.s + H - 1);
        end
      end
      if (key_down !== 1'b1) cur_valid = 1'b0;
      prev_down = (key_down === 1'b1);
    end
  end

  // Drive inputs for the next edge and advance the reference schedule.
  task automatic drive(input logic v, input logic [3:0] kp, input logic rs, output logic acc);
    int   n;
    int   s;
    ent_t e;
    @(negedge clk);
    n = cyc;
    key_valid = v;
    key_pos = kp;
    reset = rs;
    rows = pick_rows(n);
    acc = v && !rs && (pend_at(n) < 4);
    if (rs) begin
      sched.delete();
      exp_q.delete();
      last_s = -100000;
    end else if (acc) begin
      s = (n + 2 > last_s + H + G + 1) ? n + 2 : last_s + H + G + 1;
      e.key = kp;
      e.k = n + 1;
      e.s = s;
      sched.push_back(e);
      exp_q.push_back(e);
      last_s = s;
    end
    while (sched.size() > 0 && sched[0].s + H + G + 2 < n) void'(sched.pop_front());
  endtask

  task automatic idle(input int cnt);
    logic acc;
    for (int i = 0; i < cnt; i++) drive(1'b0, 4'($urandom), 1'b0, acc);
  endtask

  task automatic push_key(input logic [3:0] kp);
    logic acc = 1'b0;
    for (int i = 0; i < 400 && !acc; i++) drive(1'b1, kp, 1'b0, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout at cycle %0d: key %0h never accepted", cyc, kp);
    end
  endtask

  task automatic drain();
    logic acc;
    int   guard = 0;
    while (cyc <= last_s + H + G + 2 && guard < 3000) begin
      drive(1'b0, 4'h0, 1'b0, acc);
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout at cycle %0d: schedule still busy", cyc);
    end
  endtask

  initial begin : stimulus
    logic acc;
    int   s0;
    int   dens = 4;
    rows_mode = 1;
    rows_fixed = 4'hF;
    repeat (3) drive(1'b0, 4'h0, 1'b1, acc);

    // single key with a cycling row scan
    rows_mode = 0;
    push_key(4'b0110);
    drain();

    // active row never scanned
    rows_mode = 1;
    rows_fixed = 4'b1101;
    push_key(4'b0000);
    drain();

    // bounce-pattern scenario (steady contact in the default build)
    rows_fixed = 4'b1110;
    push_key(4'b0001);
    drain();

    // back-to-back pushes until the queue stalls
    rows_mode = 0;
    for (int i = 0; i < 6; i++) push_key(4'($urandom));
    drain();

    // push coinciding with a pop while two keys are queued
    rows_mode = 2;
    push_key(4'h5);
    s0 = last_s;
    push_key(4'h9);
    push_key(4'hA);
    for (int i = 0; i < 200 && cyc < s0 + H + G; i++) drive(1'b0, 4'h0, 1'b0, acc);
    push_key(4'hC);
    drain();

    // reset mid-press with two keys queued
    push_key(4'h3);
    push_key(4'hE);
    push_key(4'h7);
    idle(6);
    drive(1'b0, 4'h0, 1'b1, acc);
    idle(4);
    drain();

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) dens = $urandom_range(1, 12);
      if ($urandom_range(0, 199) == 0) begin
        repeat ($urandom_range(1, 3)) drive(1'b0, 4'($urandom), 1'b1, acc);
      end else begin
        drive(($urandom_range(0, 15) < dens), 4'($urandom), 1'b0, acc);
      end
    end
    drain();
    idle(2);
    chk("exp_q_empty", cyc, 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 200, clk cycles a key stays pressed (min 8).
REQ-002 Parameter GAP_CYCLES, default 200, clk cycles released between consecutive keys (min 8).
REQ-003 Parameter BOUNCE_CYCLES, default 16, bounce window length; SHALL be < HOLD_CYCLES and < GAP_CYCLES.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rows  input  4  row drive from the scanner under test, active-low; one bit low selects that row.
REQ-007 columns  output  4  emulated column sense, active-low; 4'b1111 means no contact.
REQ-008 key_pos  input  4  physical key position: row index = key_pos[3:2], column index = key_pos[1:0].
REQ-009 key_valid  input  1  request to enqueue key_pos.
REQ-010 key_ready  output  1  enqueue accepted on a cycle with key_valid & key_ready.
REQ-011 key_down  output  1  high while the FSM is in PRESS, ignoring bounce.
REQ-012 key_done  output  1  one-cycle pulse on the cycle PRESS ends.
REQ-013 pending  output  3  number of queued keys, 0..4.

Function
REQ-014 Queue: 4-entry FIFO of key_pos; key_ready = (pending != 4) and not in reset.
REQ-015 Push while full is not accepted, even if a pop occurs the same cycle; push and pop together when not full leave pending unchanged.
REQ-016 FSM states IDLE, PRESS, GAP; a 16-bit down-counter times PRESS and GAP.
REQ-017 IDLE: if pending != 0, pop head into active register, load counter HOLD_CYCLES-1, go PRESS; else stay.
REQ-018 Latency: key accepted at edge k -> key_down high after edge k+1 when IDLE and queue empty before k.
REQ-019 PRESS: decrement; at counter 0 pulse key_done, load GAP_CYCLES-1, go GAP; key_down high exactly HOLD_CYCLES cycles.
REQ-020 GAP: decrement; at counter 0 go IDLE; next key pressed no sooner than GAP_CYCLES+1 cycles after key_done.
REQ-021 Contact model: columns[c] = 0 iff contact closed, c equals active column, and rows[active row] = 0; all other bits 1.
REQ-022 columns is combinational from rows and registered state (zero-cycle response to a row change).
REQ-023 Contact closed throughout PRESS and open in IDLE/GAP when bounce emulation is absent.
REQ-024 rows with multiple bits low: column asserted if active row is among them; rows = 4'b1111 yields columns = 4'b1111.
REQ-025 Only one key is emulated at a time; no ghosting or multi-key combinations.

Reset
REQ-026 reset high at a posedge: FIFO emptied (pending=0), FSM to IDLE, counter 0, key_down=0, key_done=0, key_ready=0 while reset held.
REQ-027 Reset mid-PRESS or mid-GAP: columns = 4'b1111 from the following cycle, no key_done pulse, queued keys discarded.
REQ-028 key_ready = 1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro KEYPAD_EMU_BOUNCE_EN, when defined, compiles in contact-bounce emulation.
REQ-030 With macro: for elapsed e < BOUNCE_CYCLES in PRESS, contact closed when (e/4) even, open when odd; in GAP, contact open when (e/4) even, closed when odd; steady value after the window.
REQ-031 With macro: key_down, key_done, and pending timing identical to the non-bounce build.
REQ-032 Without macro: no bounce logic synthesized; contact follows REQ-023.

Verification
REQ-033 Single key: push 4'b0110, rows cycles 1110/1101/1011/0111 -> columns=4'b1011 only while rows=4'b1101, for HOLD_CYCLES cycles; key_done once.
REQ-034 Queue full: push 5 keys back-to-back from IDLE -> 5 accepted (one popped first), 6th stalls key_ready=0; keys pressed in push order with GAP_CYCLES spacing.
REQ-035 Reset mid-PRESS with 2 queued -> next cycle columns=4'b1111, pending=0, key_down=0, no key_done.
REQ-036 Row mismatch: active key 4'b0000, rows held 4'b1101 -> columns stays 4'b1111 throughout PRESS.
REQ-037 KEYPAD_EMU_BOUNCE_EN defined, BOUNCE_CYCLES=16, rows=4'b1110, key 4'b0001 -> columns bit1 low e=0-3, high 4-7, low 8-11, high 12-15, then low to end of PRESS; mirrored pattern in GAP.
REQ-038 Push and pop same cycle with pending=2 -> pending stays 2.
